int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl.sv | 114 +++++++++++
 tb/tb_int_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller with claim/EOI nesting and a small bus register map.
// INT_CTRL_EDGE_EN selects rising-edge source events; the default build latches on level.
module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NUM_SRC-1:0]   src,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [1:0]           addr,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    output logic                 irq
);

    localparam int VW = 5;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_VEC  = 2'd2;
    localparam logic [1:0] A_EOI  = 2'd3;

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic               irq_q, irq_d;

    logic [VW-1:0]      cand;
    logic [VW-1:0]      svc;
    logic [NUM_SRC-1:0] src_evt;
    logic [NUM_SRC-1:0] claim_oh;
    logic [NUM_SRC-1:0] eoi_oh;
    logic               wr_pend, wr_mask, wr_eoi, claim_en;
    logic               unused_sink;

    // Lowest index wins, so scan from the top and let lower indices overwrite.
    always_comb begin
        cand = VW'(NUM_SRC);
        svc  = VW'(NUM_SRC);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending_q[i] && mask_q[i]) cand = VW'(i);
            if (in_service_q[i])           svc  = VW'(i);
        end
    end

`ifdef INT_CTRL_EDGE_EN
    assign src_evt = src & ~src_q;
    assign src_d   = src;
`else
    assign src_evt = src;
    assign src_d   = '0;
`endif

    // A simultaneous read and write is a write; the claim is suppressed.
    assign wr_pend  = wr && (addr == A_PEND);
    assign wr_mask  = wr && (addr == A_MASK);
    assign wr_eoi   = wr && (addr == A_EOI);
    assign claim_en = rd && !wr && (addr == A_VEC) && (cand < VW'(NUM_SRC));

    always_comb begin
        claim_oh = '0;
        eoi_oh   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_oh[i] = claim_en && (cand == VW'(i));
            eoi_oh[i]   = wr_eoi && (data_in[3:0] == 4'(i));
        end
    end

    // Set events are OR-ed in last so they win over W1C and claim clears.
    always_comb begin
        pending_d    = pending_q & ~claim_oh;
        if (wr_pend) pending_d = pending_d & ~data_in[NUM_SRC-1:0];
        pending_d    = pending_d | src_evt;
        mask_d       = wr_mask ? data_in[NUM_SRC-1:0] : mask_q;
        in_service_d = (in_service_q | claim_oh) & ~eoi_oh;
        irq_d        = (cand < svc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q    <= '0;
            mask_q       <= '0;
            in_service_q <= '0;
            src_q        <= '0;
            irq_q        <= 1'b0;
        end else if (en) begin
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            src_q        <= src_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        data_out = '0;
        if (rd) begin
            case (addr)
                A_PEND:  data_out = 32'(pending_q);
                A_MASK:  data_out = 32'(mask_q);
                A_VEC:   data_out = 32'(cand);
                default: data_out = '0;
            endcase
        end
    end

    assign irq = irq_q;

    assign unused_sink = ^{data_in, src_q};

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by random bus/source traffic,
// all compared against a behavioural model of the register map and priority rules.
module tb_int_ctrl;

    localparam int N = 8;

`ifdef INT_CTRL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic          clk;
    logic          rst_n, en, rd, wr;
    logic [1:0]    addr;
    logic [31:0]   data_in, data_out;
    logic [N-1:0]  src;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_dout;

    bit [15:0] m_pend, m_mask, m_isvc, m_srcq;
    bit        m_irq;

    int_ctrl #(.NUM_SRC(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .src      (src),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_cand();
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_mask[i]) return i;
        return N;
    endfunction

    function automatic int m_svc();
        for (int i = 0; i < N; i++)
            if (m_isvc[i]) return i;
        return N;
    endfunction

    function automatic logic [31:0] m_read(input bit r, input logic [1:0] a);
        if (!r) return 0;
        case (a)
            2'd0:    return 32'(m_pend);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_cand());
            default: return 0;
        endcase
    endfunction

    // One bus cycle: drive at negedge, check the combinational read, then check state after the edge.
    task automatic step(input bit r, input bit e, input bit rdv, input bit wrv,
                        input logic [1:0] a, input logic [31:0] d, input logic [N-1:0] s_in);
        int c, s, idx;
        bit [15:0] np, nm, ni, nq;
        bit nirq;
        @(negedge clk);
        rst_n = r; en = e; rd = rdv; wr = wrv; addr = a; data_in = d; src = s_in;
        #1;
        last_dout = data_out;
        check_eq("data_out", data_out, m_read(rdv, a));
        c = m_cand();
        s = m_svc();
        np = m_pend; nm = m_mask; ni = m_isvc; nq = m_srcq; nirq = m_irq;
        if (!r) begin
            np = 0; nm = 0; ni = 0; nq = 0; nirq = 0;
        end else if (e) begin
            nirq = (c < s);
            if (wrv) begin
                if (a == 2'd0) for (int i = 0; i < N; i++) if (d[i]) np[i] = 0;
                if (a == 2'd1) for (int i = 0; i < N; i++) nm[i] = d[i];
                if (a == 2'd3) begin
                    idx = int'(d[3:0]);
                    if (idx < N) ni[idx] = 0;
                end
            end else if (rdv && a == 2'd2 && c < N) begin
                np[c] = 0;
                ni[c] = 1;
            end
            for (int i = 0; i < N; i++) begin
                if (EDGE ? (s_in[i] && !m_srcq[i]) : s_in[i]) np[i] = 1;
                nq[i] = EDGE ? s_in[i] : 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_pend = np; m_mask = nm; m_isvc = ni; m_srcq = nq; m_irq = nirq;
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("pending", 32'(dut.pending_q), 32'(m_pend));
        check_eq("mask", 32'(dut.mask_q), 32'(m_mask));
        check_eq("in_service", 32'(dut.in_service_q), 32'(m_isvc));
    endtask

    task automatic nop(input logic [N-1:0] s_in);
        step(1, 1, 0, 0, 2'd0, 32'h0, s_in);
    endtask

    initial begin
        logic [N-1:0] s_rand;
        logic [1:0]   a_rand;
        logic [31:0]  d_rand;
        rst_n = 1'b0; en = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'd0; data_in = '0; src = '0;
        m_pend = 0; m_mask = 0; m_isvc = 0; m_srcq = 0; m_irq = 0;

        step(0, 1, 0, 0, 2'd0, 32'h0, 8'h00);
        step(0, 1, 0, 0, 2'd0, 32'h0, 8'h00);
        check_eq("reset_irq", 32'(irq), 32'h0);

        // Edge latch and claim of source 0.
        step(1, 1, 0, 1, 2'd1, 32'h01, 8'h00);
        step(1, 1, 0, 0, 2'd0, 32'h0, 8'h01);
        step(1, 1, 1, 0, 2'd0, 32'h0, 8'h01);
        check_eq("latch_pend", last_dout, 32'h01);
        check_eq("latch_irq", 32'(irq), 32'h1);
        step(1, 1, 1, 0, 2'd2, 32'h0, 8'h01);
        check_eq("latch_vec", last_dout, 32'h0);
        step(1, 1, 1, 0, 2'd0, 32'h0, 8'h01);
        check_eq("claim_pend", last_dout, EDGE ? 32'h0 : 32'h1);
        nop(8'h00);
        step(1, 1, 0, 1, 2'd3, 32'h0, 8'h00);
        step(1, 1, 0, 1, 2'd0, 32'hFF, 8'h00);
        nop(8'h00);

        // Priority: sources 5 and 2 pending together.
        step(1, 1, 0, 1, 2'd1, 32'hFF, 8'h00);
        nop(8'h24);
        nop(8'h00);
        step(1, 1, 1, 0, 2'd2, 32'h0, 8'h00);
        check_eq("prio_first", last_dout, 32'd2);
        step(1, 1, 0, 1, 2'd3, 32'd2, 8'h00);
        step(1, 1, 1, 0, 2'd2, 32'h0, 8'h00);
        check_eq("prio_second", last_dout, 32'd5);

        // Nesting with source 5 in service.
        nop(8'h08);
        nop(8'h00);
        check_eq("nest_preempt", 32'(irq), 32'h1);
        step(1, 1, 0, 1, 2'd0, 32'h08, 8'h00);
        nop(8'h00);
        nop(8'h40);
        nop(8'h00);
        nop(8'h00);
        check_eq("nest_lower_blocked", 32'(irq), 32'h0);
        step(1, 1, 0, 1, 2'd3, 32'd5, 8'h00);
        nop(8'h00);
        check_eq("nest_after_eoi", 32'(irq), 32'h1);
        step(1, 1, 0, 1, 2'd0, 32'hFF, 8'h00);
        nop(8'h00);

        // W1C and set event in the same cycle.
        step(1, 1, 0, 1, 2'd0, 32'h04, 8'h04);
        step(1, 1, 1, 0, 2'd0, 32'h0, 8'h00);
        check_eq("w1c_vs_set", last_dout & 32'h4, 32'h4);
        step(1, 1, 0, 1, 2'd0, 32'hFF, 8'h00);
        nop(8'h00);

        // Empty claim.
        step(1, 1, 1, 0, 2'd2, 32'h0, 8'h00);
        check_eq("empty_vec", last_dout, 32'd8);
        check_eq("empty_isvc", 32'(dut.in_service_q), 32'h0);

        // Reset coincident with a claim.
        nop(8'h02);
        nop(8'h00);
        step(0, 1, 1, 0, 2'd2, 32'h0, 8'h00);
        check_eq("rst_claim_pend", 32'(dut.pending_q), 32'h0);
        check_eq("rst_claim_mask", 32'(dut.mask_q), 32'h0);
        check_eq("rst_claim_isvc", 32'(dut.in_service_q), 32'h0);
        check_eq("rst_claim_irq", 32'(irq), 32'h0);
        nop(8'h00);

        // Random traffic.
        s_rand = '0;
        for (int k = 0; k < 3000; k++) begin
            s_rand = s_rand ^ N'($urandom & $urandom & $urandom);
            a_rand = 2'($urandom_range(0, 3));
            d_rand = $urandom;
            if (a_rand == 2'd3) d_rand = $urandom_range(0, 15);
            step($urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 a_rand, d_rand, s_rand);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
